// File: rtl/cdc_pkg.sv
// cdc_pkg: shared definitions for the async-to-sync CDC receive path.
//   DW_DEFAULT - default data word width of the CDC Din bus
//   rx_state_e - receive handshake FSM states
package cdc_pkg;

    localparam int DW_DEFAULT = 64;

    typedef enum logic {
        RX_IDLE = 1'b0,   // So=0, waiting for a request
        RX_ACK  = 1'b1    // So=1, waiting for the request to return to zero
    } rx_state_e;

endpackage : cdc_pkg

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with extra-MSB pointers.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   push, push_data     write request and word (ignored while full)
//   pop, pop_data       read request (ignored while empty), head word
//   full, empty, level  occupancy status, level in 0..DEPTH
module sync_fifo
    import cdc_pkg::*;
#(
    parameter  int DW    = DW_DEFAULT,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [LW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LW-1:0] rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          do_push, do_pop;

    // Status comes straight from the registered pointers, so a pop in the
    // current cycle never frees a slot for a push in the same cycle.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level    = wr_ptr_q - rd_ptr_q;
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + LW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + LW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: contents are only observable when not empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule : sync_fifo

// File: rtl/cdc_sync_rx.sv
// cdc_sync_rx: synchronous-side receiver of the CDC 4-phase word handshake.
// Captures one Din word per Si pulse into a FIFO and re-presents the words
// as a valid/ready stream; counts received words.
// Ports:
//   CLK, RESET           clock, asynchronous active-low reset
//   Din, Si, So          CDC word bus, request, acknowledge
//   out_data/valid/ready consumer stream
//   level                FIFO occupancy 0..DEPTH
//   rx_count             words accepted since reset, wraps mod 2^CW
module cdc_sync_rx
    import cdc_pkg::*;
#(
    parameter  int DW    = DW_DEFAULT,
    parameter  int DEPTH = 4,
    parameter  int CW    = 32,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [DW-1:0] Din,
    input  logic          Si,
    output logic          So,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [LW-1:0] level,
    output logic [CW-1:0] rx_count
);

    rx_state_e     state_q, state_d;
    logic [CW-1:0] rx_count_q, rx_count_d;
    logic          push, pop, full, empty;

    // Capture only on the IDLE->ACK transition, so each Si pulse yields
    // exactly one word; a full FIFO holds So low to stall the CDC.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                if (Si && !full) begin
                    push    = 1'b1;
                    state_d = RX_ACK;
                end
            end
            RX_ACK: begin
                if (!Si) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign rx_count_d = push ? rx_count_q + CW'(1) : rx_count_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= RX_IDLE;
            rx_count_q <= '0;
        end else begin
            state_q    <= state_d;
            rx_count_q <= rx_count_d;
        end
    end

    // So is decoded from the state register so reset drops it immediately.
    assign So        = (state_q == RX_ACK);
    assign rx_count  = rx_count_q;
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;

    sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (RESET),
        .push      (push),
        .push_data (Din),
        .pop       (pop),
        .pop_data  (out_data),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

endmodule : cdc_sync_rx

// File: tb/tb_cdc_sync_rx.sv
module tb_cdc_sync_rx;

    localparam int DW    = 64;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          CLK = 1'b0;
    logic          RESET = 1'b0;
    logic [DW-1:0] Din = '0;
    logic          Si = 1'b0;
    logic          out_ready = 1'b0;
    logic          So, out_valid;
    logic [DW-1:0] out_data;
    logic [LW-1:0] level;
    logic [31:0]   rx_count;

    // Narrow-counter instance sharing the same stimulus, for the wrap check.
    logic          So_w, out_valid_w;
    logic [DW-1:0] out_data_w;
    logic [LW-1:0] level_w;
    logic [3:0]    rx_count_w;

    int n_chk  = 0;
    int n_fail = 0;
    int n_words = 0;          // model: words accepted since reset
    logic [DW-1:0] exp_q[$];  // model: words expected on the output stream
    bit  trk = 0;
    int  max_lvl = 0;

    always #5 CLK = ~CLK;

    cdc_sync_rx #(.DW(DW), .DEPTH(DEPTH), .CW(32)) dut (
        .CLK(CLK), .RESET(RESET), .Din(Din), .Si(Si), .So(So),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level), .rx_count(rx_count)
    );

    cdc_sync_rx #(.DW(DW), .DEPTH(DEPTH), .CW(4)) dut_w (
        .CLK(CLK), .RESET(RESET), .Din(Din), .Si(Si), .So(So_w),
        .out_data(out_data_w), .out_valid(out_valid_w), .out_ready(out_ready),
        .level(level_w), .rx_count(rx_count_w)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_counts();
        check("rx_count", 64'(rx_count), 64'(n_words));
        check("rx_count_cw4", 64'(rx_count_w), 64'(n_words % 16));
    endtask

    // Monitor: every accepted output beat must be the oldest outstanding word.
    always @(negedge CLK) begin
        if (RESET && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL pop_underflow: got %h expected no word", out_data);
            end else begin
                check("out_data", out_data, exp_q.pop_front());
            end
        end
        if (trk && int'(level) > max_lvl) max_lvl = int'(level);
    end

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic do_reset();
        RESET = 1'b0; Si = 1'b0; out_ready = 1'b0;
        exp_q.delete(); n_words = 0;
        repeat (2) @(posedge CLK);
        @(negedge CLK); RESET = 1'b1;
        tick();
    endtask

    // One complete 4-phase handshake with a random Si turnaround.
    task automatic send(input logic [DW-1:0] w);
        int i;
        repeat ($urandom_range(0, 2)) tick();
        Din = w; Si = 1'b1; exp_q.push_back(w);
        for (i = 0; i < 100 && So !== 1'b1; i++) tick();
        check("so_rise", 64'(So), 64'd1);
        n_words++;
        check_counts();
        Si = 1'b0; Din = {$urandom, $urandom};   // ignored while Si=0
        for (i = 0; i < 100 && So !== 1'b0; i++) tick();
        check("so_fall", 64'(So), 64'd0);
    endtask

    task automatic drain();
        int i;
        out_ready = 1'b1;
        for (i = 0; i < 100 && level != 0; i++) tick();
        check("drain_level", 64'(level), 64'd0);
        check("drain_queue", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic fill4();
        out_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) send({$urandom, $urandom});
        check("fill_level", 64'(level), 64'(DEPTH));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] w5;
        // Reset values
        RESET = 1'b0; #3;
        check("rst_so", 64'(So), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_count", 64'(rx_count), 64'd0);
        do_reset();

        // Single handshake, 1-cycle latency
        Din = 64'hDEADBEEF_01234567; Si = 1'b1; exp_q.push_back(Din);
        tick();
        n_words++;
        check("t1_so", 64'(So), 64'd1);
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_data", out_data, 64'hDEADBEEF_01234567);
        check_counts();
        Si = 1'b0; Din = '1;
        tick();
        check("t1_so_fall", 64'(So), 64'd0);
        check("t1_data_hold", out_data, 64'hDEADBEEF_01234567);
        drain();

        // 16 random words streaming, then the 17th shows the narrow wrap
        do_reset();
        out_ready = 1'b1; max_lvl = 0; trk = 1;
        for (int k = 0; k < 16; k++) send({$urandom, $urandom});
        trk = 0;
        check("t2_count16", 64'(rx_count), 64'd16);
        check("t2_wrap0", 64'(rx_count_w), 64'd0);
        check("t2_maxlvl_le1", 64'(max_lvl <= 1), 64'd1);
        send({$urandom, $urandom});
        check("t2_wrap1", 64'(rx_count_w), 64'd1);
        drain();

        // Back-pressure: fifth word waits until a pop frees a slot
        fill4();
        w5 = {$urandom, $urandom};
        Din = w5; Si = 1'b1; exp_q.push_back(w5);
        repeat (3) begin
            tick();
            check("t3_stall_so", 64'(So), 64'd0);
            check("t3_stall_lvl", 64'(level), 64'(DEPTH));
        end
        out_ready = 1'b1;
        tick();
        check("t3_pop_so", 64'(So), 64'd0);
        check("t3_pop_lvl", 64'(level), 64'(DEPTH - 1));
        tick();
        n_words++;
        check("t3_cap_so", 64'(So), 64'd1);
        check("t3_cap_lvl", 64'(level), 64'(DEPTH - 1));
        check_counts();
        Si = 1'b0;
        drain();

        // Full FIFO, Si and out_ready together: pop first, push next cycle
        fill4();
        w5 = {$urandom, $urandom};
        Din = w5; Si = 1'b1; exp_q.push_back(w5); out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t4_lvl3", 64'(level), 64'(DEPTH - 1));
        check("t4_so0", 64'(So), 64'd0);
        tick();
        n_words++;
        check("t4_lvl4", 64'(level), 64'(DEPTH));
        check("t4_so1", 64'(So), 64'd1);
        check_counts();
        Si = 1'b0;
        tick();
        check("t4_so_fall", 64'(So), 64'd0);
        drain();

        // Asynchronous reset in the middle of an ACK with two words buffered
        out_ready = 1'b0;
        send({$urandom, $urandom});
        w5 = {$urandom, $urandom};
        Din = w5; Si = 1'b1; exp_q.push_back(w5);
        tick();
        check("t5_so", 64'(So), 64'd1);
        check("t5_lvl2", 64'(level), 64'd2);
        #2 RESET = 1'b0;
        #1;
        check("t5_rst_so", 64'(So), 64'd0);
        check("t5_rst_valid", 64'(out_valid), 64'd0);
        check("t5_rst_lvl", 64'(level), 64'd0);
        check("t5_rst_count", 64'(rx_count), 64'd0);
        exp_q.delete(); n_words = 0; Si = 1'b0;
        @(negedge CLK); RESET = 1'b1;
        tick();
        send({$urandom, $urandom});
        check("t5_count1", 64'(rx_count), 64'd1);
        drain();

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_cdc_sync_rx
